multi_mode_counter: RTL
=======================

// Module: multi_mode_counter
// PURPOSE
//  Parametrised synchronous counter with one datapath for binary, modulo-N (BCD when N=10),
//  one-hot ring and Johnson modes, each counting up or down. Adds clear, parallel load and a
//  terminal-count output for cascading stages (seconds/minutes digits, LED sequencers).
//  Supersedes the fixed 4-bit up/down, BCD and ring counters in the timer path.
// PARAMETERS
//  WIDTH      4        count width in bits; 2..16
//  MODULUS    10       modulo-mode period; legal range 2..2**WIDTH
//  RING_INIT  1        ring-mode seed and recovery value; must be one-hot in WIDTH bits
// PORTS
//  clk         in   1      clock, rising edge
//  reset_p     in   1      asynchronous, active-high reset
//  enable      in   1      count step enable; also the carry-in when cascading
//  clear       in   1      synchronous clear to 0
//  load        in   1      synchronous parallel load
//  load_value  in   WIDTH  value written when load=1
//  mode        in   2      00 binary, 01 modulo, 10 ring, 11 Johnson
//  up_down     in   1      1 = up / rotate left, 0 = down / rotate right
//  count       out  WIDTH  counter register
//  tc          out  1      combinational: enable & (count is terminal for current mode/dir)
//  wrap        out  1      registered one-cycle pulse: previous cycle stepped through terminal
// BEHAVIOUR
//  - Reset (async): count=0, wrap=0. All transitions occur on posedge clk only.
//  - Priority each edge: clear > load > enable > hold. clear/load ignore enable; wrap<=0 on both.
//  - Step (enable=1), next value by mode:
//    binary : count +/- 1 modulo 2**WIDTH (F->0 up, 0->F down).
//    modulo : up: count>=MODULUS-1 -> 0, else +1; down: count==0 or count>=MODULUS -> MODULUS-1,
//             else -1. An out-of-range value (load, mode change) recovers in one step; never
//             passes through MODULUS..2**WIDTH-1.
//    ring   : if count not one-hot -> RING_INIT; else rotate left (up) / right (down), circular.
//    johnson: up {count[W-2:0], ~count[W-1]}; down {~count[0], count[W-1:1]}. 2*WIDTH states.
//             Illegal Johnson patterns -> 0 on next step.
//  - Terminal value (tc source): binary up all-ones, down 0; modulo up MODULUS-1, down 0;
//    ring: next rotation equals RING_INIT; johnson up {1,0..0}, down {0..0,1}.
//    tc is 0 when enable=0. Out-of-range/illegal states never assert tc.
//  - wrap <= enable & tc & ~clear & ~load; latency 1 cycle after the terminal step.
//  - Cascade: stage n+1 enable = stage n tc -> digits advance on the same edge, no extra latency.
//  - mode/up_down changes take effect on the next step; count is not altered by the change.
//  - load_value loads verbatim in all modes (no clamping); recovery rules above apply next step.
//  - enable held 0: count and wrap stable (wrap drops to 0 after one cycle).
//  - reset_p asserted mid-count forces count=0, wrap=0 immediately, independent of clk.
//  - Ring mode from reset (count=0) loads RING_INIT on first step.
// TESTING (WIDTH=4, MODULUS=10, RING_INIT=1)
//  - binary up, enable=1 from reset, 17 clocks -> 0..F,0,1; tc=1 only at F; wrap=1 cycle after F->0.
//  - modulo down from reset, 3 clocks -> 9,8,7; tc high at count=0 before the first step.
//  - modulo up, load 4'hC then step -> count 0; load 4'hD, up_down=0, step -> 9; never 10..15.
//  - ring up 5 steps from reset -> 1,2,4,8,1; load 4'b0110 then step -> 0001; down from 1 -> 8.
//  - johnson up 9 steps from 0 -> 1,3,7,F,E,C,8,0,1; tc at 8 with enable=1; down from 0 -> 8.
//  - two cascaded instances (units tc -> tens enable), modulo up, 100 clocks -> tens:units 9:9 -> 0:0;
//    reset_p pulsed mid-count between edges -> both 0 asynchronously; clear+load same cycle -> 0.

Source files
------------

// File: rtl/multi_mode_counter_if.sv
// Control/status bundle of one multi_mode_counter stage: step controls in, count and
// cascade outputs back out to whoever drives the stage.
interface multi_mode_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [1:0]       mode;
  logic             up_down;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output enable, clear, load, load_value, mode, up_down,
    input  count, tc, wrap
  );

  modport slave (
    input  enable, clear, load, load_value, mode, up_down,
    output count, tc, wrap
  );
endinterface

// File: rtl/multi_mode_counter.sv
// Multi-mode up/down counter: binary, modulo-N, one-hot ring and Johnson sequences sharing
// one register, with clear, parallel load, combinational terminal count and a wrap pulse.
module multi_mode_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RING_INIT = 1
) (
  input  logic                clk,
  input  logic                reset_p,
  multi_mode_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'b00,
    MODE_MODULO  = 2'b01,
    MODE_RING    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] MOD_LAST  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RING_SEED = WIDTH'(RING_INIT);
  localparam logic [WIDTH-1:0] JOHN_TOP  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0] JOHN_BOT  = WIDTH'(1);

  mode_e            mode_sel;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] john_up;
  logic [WIDTH-1:0] john_down;
  logic [WIDTH-2:0] john_edges;
  logic             is_onehot;
  logic             john_legal;
  logic             in_range;
  logic             terminal;

  assign mode_sel   = mode_e'(bus.mode);
  assign rot_left   = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
  assign rot_right  = {count_q[0], count_q[WIDTH-1:1]};
  assign john_up    = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
  assign john_down  = {~count_q[0], count_q[WIDTH-1:1]};
  assign is_onehot  = $onehot(count_q);
  assign in_range   = {1'b0, count_q} < MOD_EXT;

  // A legal Johnson word is a single run of ones, so adjacent bits differ at most once.
  assign john_edges = count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0];
  assign john_legal = $onehot0(john_edges);

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count_q;
    terminal   = 1'b0;
    case (mode_sel)
      MODE_BINARY: begin
        count_next = bus.up_down ? count_q + 1'b1 : count_q - 1'b1;
        terminal   = bus.up_down ? (count_q == ALL_ONES) : (count_q == '0);
      end
      MODE_MODULO: begin
        if (bus.up_down) begin
          count_next = (count_q >= MOD_LAST) ? '0 : count_q + 1'b1;
          terminal   = (count_q == MOD_LAST);
        end else begin
          count_next = (count_q == '0 || !in_range) ? MOD_LAST : count_q - 1'b1;
          terminal   = (count_q == '0);
        end
      end
      MODE_RING: begin
        if (!is_onehot) begin
          count_next = RING_SEED;
        end else begin
          count_next = bus.up_down ? rot_left : rot_right;
          terminal   = (count_next == RING_SEED);
        end
      end
      MODE_JOHNSON: begin
        if (!john_legal) begin
          count_next = '0;
        end else begin
          count_next = bus.up_down ? john_up : john_down;
          terminal   = bus.up_down ? (count_q == JOHN_TOP) : (count_q == JOHN_BOT);
        end
      end
      default: begin
        count_next = count_q;
        terminal   = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= bus.load_value;
      wrap_q  <= 1'b0;
    end else if (bus.enable) begin
      count_q <= count_next;
      wrap_q  <= terminal;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = bus.enable & terminal;
  assign bus.wrap  = wrap_q;

endmodule
